// File: rtl/job_arbiter_rr_if.sv
// Request/grant and engine handshake bundle for job_arbiter_rr.
// master = client/engine side, slave = arbiter side.
interface job_arbiter_rr_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] cancel;
  logic [NREQ-1:0] grant;
  logic [NREQ-1:0] ack;
  logic [NREQ-1:0] err;
  logic            busy;
  logic            go_o;
  logic            kill_o;
  logic            done_i;

  modport master (
    output req, cancel, done_i,
    input  grant, ack, err, busy, go_o, kill_o
  );

  modport slave (
    input  req, cancel, done_i,
    output grant, ack, err, busy, go_o, kill_o
  );
endinterface

// File: rtl/job_arbiter_rr.sv
// Round-robin arbiter sharing one go/kill/done job engine among NREQ requesters.
// Define JOB_ARB_STATS_EN to add saturating done_cnt/abort_cnt outputs.
module job_arbiter_rr #(
  parameter int NREQ        = 4,
  parameter int TIMEOUT     = 200,
  parameter int KILL_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  job_arbiter_rr_if.slave      bus
`ifdef JOB_ARB_STATS_EN
  ,
  output logic [15:0]          done_cnt,
  output logic [15:0]          abort_cnt
`endif
);

  localparam int PW   = $clog2(NREQ);
  localparam int TMAX = (TIMEOUT > KILL_CYCLES) ? TIMEOUT : KILL_CYCLES;
  localparam int TW   = $clog2(TMAX);

  typedef enum logic [1:0] {IDLE, START, RUN, KILL} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d, win_q, win_d, win_sel, next_ptr;
  logic [TW-1:0]   timer_q, timer_d;
  logic [NREQ-1:0] grant_q, grant_d, ack_q, ack_d, err_q, err_d;
  logic            busy_q, busy_d, go_q, go_d, kill_q, kill_d;
  logic            found;

  // First requester at or after the pointer, wrapping modulo NREQ.
  always_comb begin
    found   = 1'b0;
    win_sel = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      int unsigned idx;
      idx = int'(ptr_q) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && bus.req[idx]) begin
        found   = 1'b1;
        win_sel = PW'(idx);
      end
    end
  end

  assign next_ptr = (win_q == PW'(NREQ - 1)) ? '0 : win_q + PW'(1);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    timer_d = timer_q;
    grant_d = grant_q;
    busy_d  = busy_q;
    kill_d  = kill_q;
    go_d    = 1'b0;
    ack_d   = '0;
    err_d   = '0;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d = START;
          win_d   = win_sel;
          grant_d = NREQ'(1) << win_sel;
          busy_d  = 1'b1;
          go_d    = 1'b1;
        end
      end
      START: begin
        state_d = RUN;
        timer_d = '0;
      end
      RUN: begin
        timer_d = timer_q + TW'(1);
        // done has priority over cancel/timeout in the same cycle
        if (bus.done_i) begin
          state_d = IDLE;
          ack_d   = grant_q;
          grant_d = '0;
          busy_d  = 1'b0;
          ptr_d   = next_ptr;
        end else if (bus.cancel[win_q] || timer_q == TW'(TIMEOUT - 1)) begin
          state_d = KILL;
          kill_d  = 1'b1;
          timer_d = '0;
        end
      end
      KILL: begin
        if (timer_q == TW'(KILL_CYCLES - 1)) begin
          state_d = IDLE;
          kill_d  = 1'b0;
          err_d   = grant_q;
          grant_d = '0;
          busy_d  = 1'b0;
          ptr_d   = next_ptr;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      win_q   <= '0;
      timer_q <= '0;
      grant_q <= '0;
      ack_q   <= '0;
      err_q   <= '0;
      busy_q  <= 1'b0;
      go_q    <= 1'b0;
      kill_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      timer_q <= timer_d;
      grant_q <= grant_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      go_q    <= go_d;
      kill_q  <= kill_d;
    end
  end

  assign bus.grant  = grant_q;
  assign bus.ack    = ack_q;
  assign bus.err    = err_q;
  assign bus.busy   = busy_q;
  assign bus.go_o   = go_q;
  assign bus.kill_o = kill_q;

`ifdef JOB_ARB_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      done_cnt  <= '0;
      abort_cnt <= '0;
    end else begin
      if (|ack_q && done_cnt != '1)  done_cnt  <= done_cnt + 16'd1;
      if (|err_q && abort_cnt != '1) abort_cnt <= abort_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_job_arbiter_rr.sv
// Directed self-checking bench for job_arbiter_rr (NREQ=4, TIMEOUT=20, KILL_CYCLES=2).
module tb_job_arbiter_rr;
  localparam int NREQ = 4;
  localparam int TOUT = 20;
  localparam int KC   = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  job_arbiter_rr_if #(.NREQ(NREQ)) bus ();

`ifdef JOB_ARB_STATS_EN
  logic [15:0] done_cnt, abort_cnt;
`endif

  job_arbiter_rr #(.NREQ(NREQ), .TIMEOUT(TOUT), .KILL_CYCLES(KC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
`ifdef JOB_ARB_STATS_EN
    ,
    .done_cnt  (done_cnt),
    .abort_cnt (abort_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.req = '0;
    bus.cancel = '0;
    bus.done_i = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Wait (bounded) for go_o, then check the granted owner.
  task automatic wait_go(input string tag, input logic [3:0] exp_grant);
    int n = 0;
    do begin
      tick();
      n++;
    end while (!bus.go_o && n < 50);
    check({tag, "_go"}, bus.go_o, 1);
    check({tag, "_grant"}, bus.grant, exp_grant);
    check({tag, "_nokill"}, bus.kill_o, 0);
  endtask

  // Full job: go, RUN for 'len' cycles after go, then done -> ack.
  task automatic do_job(input string tag, input logic [3:0] exp_grant, input int len);
    wait_go(tag, exp_grant);
    repeat (len - 1) tick();
    bus.done_i = 1'b1;
    tick();
    bus.done_i = 1'b0;
    check({tag, "_ack"}, bus.ack, exp_grant);
    check({tag, "_err"}, bus.err, 0);
    check({tag, "_rel"}, {bus.grant, bus.busy}, 0);
  endtask

  initial begin
    bus.req = '0;
    bus.cancel = '0;
    bus.done_i = 1'b0;
    do_reset();
    check("rst_out", {bus.grant, bus.ack, bus.err, bus.busy, bus.go_o, bus.kill_o}, 0);

    // Single job on requester 1; pointer must land on 2.
    bus.req = 4'b0010;
    tick();
    check("single_go_lat", bus.go_o, 1);
    check("single_grant", bus.grant, 4'b0010);
    check("single_busy", bus.busy, 1);
    tick();
    check("single_go_pulse", bus.go_o, 0);
    repeat (8) tick();
    bus.done_i = 1'b1;
    tick();
    bus.done_i = 1'b0;
    bus.req = '0;
    check("single_ack", bus.ack, 4'b0010);
    check("single_rel", {bus.grant, bus.busy}, 0);
    tick();
    check("single_ack_pulse", bus.ack, 0);
    bus.req = 4'b1111;
    do_job("ptr2", 4'b0100, 3);
    bus.req = '0;

    // Round robin from pointer 0 with all requests high.
    do_reset();
    bus.req = 4'b1111;
    do_job("rr0", 4'b0001, 5);
    do_job("rr1", 4'b0010, 5);
    do_job("rr2", 4'b0100, 5);
    do_job("rr3", 4'b1000, 5);
    do_job("rr4", 4'b0001, 5);
    bus.req = '0;

    // Timeout: kill after TOUT RUN cycles, held KC cycles; done during KILL ignored.
    do_reset();
    bus.req = 4'b0001;
    wait_go("to", 4'b0001);
    bus.req = '0;
    begin
      int n = 0;
      do begin
        tick();
        n++;
      end while (!bus.kill_o && n < 200);
      check("to_kill_lat", n, TOUT + 1);
    end
    check("to_go_kill_excl", bus.go_o, 0);
    bus.done_i = 1'b1;
    tick();
    bus.done_i = 1'b0;
    check("to_kill_hold", bus.kill_o, 1);
    check("to_done_ignored", bus.ack, 0);
    tick();
    check("to_kill_drop", bus.kill_o, 0);
    check("to_err", bus.err, 4'b0001);
    check("to_rel", {bus.grant, bus.busy, bus.ack}, 0);

    // Foreign cancel ignored; cancel+done together -> ack wins.
    do_reset();
    bus.req = 4'b0100;
    wait_go("cd", 4'b0100);
    bus.req = '0;
    bus.cancel = 4'b0010;
    repeat (3) tick();
    check("cd_foreign_cancel", {bus.kill_o, bus.grant}, 5'b0_0100);
    bus.cancel = 4'b0100;
    bus.done_i = 1'b1;
    tick();
    bus.cancel = '0;
    bus.done_i = 1'b0;
    check("cd_ack", bus.ack, 4'b0100);
    check("cd_err", bus.err, 0);
    check("cd_kill", bus.kill_o, 0);
    tick();
    check("cd_kill_after", bus.kill_o, 0);

    // Reset during KILL drops everything asynchronously.
    do_reset();
    bus.req = 4'b0001;
    wait_go("rk", 4'b0001);
    bus.req = '0;
    tick();
    bus.cancel = 4'b0001;
    tick();
    bus.cancel = '0;
    check("rk_kill_on", bus.kill_o, 1);
    #2;
    reset = 1'b1;
    #1;
    check("rk_async_out", {bus.grant, bus.ack, bus.err, bus.busy, bus.go_o, bus.kill_o}, 0);
    tick();
    reset = 1'b0;
    bus.req = 4'b1000;
    wait_go("rk_after", 4'b1000);
    bus.req = '0;
    repeat (2) tick();
    bus.done_i = 1'b1;
    tick();
    bus.done_i = 1'b0;
    check("rk_after_ack", bus.ack, 4'b1000);

`ifdef JOB_ARB_STATS_EN
    do_reset();
    check("st_rst", {done_cnt, abort_cnt}, 0);
    bus.req = 4'b0010;
    for (int j = 0; j < 3; j++) do_job("st_job", 4'b0010, 2);
    bus.req = '0;
    for (int j = 0; j < 2; j++) begin
      int n = 0;
      bus.req = 4'b0010;
      wait_go("st_to", 4'b0010);
      bus.req = '0;
      do begin
        tick();
        n++;
      end while (bus.err == '0 && n < 200);
      check("st_to_err", bus.err, 4'b0010);
    end
    tick();
    check("st_done_cnt", done_cnt, 3);
    check("st_abort_cnt", abort_cnt, 2);
    do_reset();
    check("st_clr", {done_cnt, abort_cnt}, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/job_arbiter_rr.md
Name: job_arbiter_rr

Overview:
- Round-robin scheduler that shares one go/kill/done job engine among NREQ requesters.
- Accepts requests, issues a one-cycle go to the engine, and supervises the job with a watchdog and per-requester cancel.
- Reports completion (ack) or abort (err) to the granted requester.
- Sits between client logic and the single counting job engine; it is the only driver of that engine's go and kill.

Parameters:
- NREQ, 4, number of requesters (2..8).
- TIMEOUT, 200, max RUN cycles before forced kill (>= 2).
- KILL_CYCLES, 2, cycles kill_o is held high per abort (>= 1).

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high; clears all state and outputs.
- req  in  NREQ  level request per requester.
- cancel  in  NREQ  level abort request; only the granted bit is honoured.
- grant  out  NREQ  one-hot owner of the engine; 0 when idle.
- ack  out  NREQ  one-cycle pulse to owner on successful completion.
- err  out  NREQ  one-cycle pulse to owner on abort (cancel or timeout).
- busy  out  1  high in every state except IDLE.
- go_o  out  1  one-cycle start pulse to engine.
- kill_o  out  1  abort level to engine.
- done_i  in  1  one-cycle completion pulse from engine.

Behaviour:
- All outputs are registered. Reset values: grant=0, ack=0, err=0, busy=0, go_o=0, kill_o=0. Internally, rr pointer=0, timer=0, state=IDLE.
- States are IDLE, START, RUN, KILL. Transitions:
  - IDLE: if any req bit is set, the winner is the first set bit at or after the pointer, wrapping modulo NREQ. Next cycle: state=START, grant=onehot(winner), go_o=1, busy=1. With no req, stay in IDLE.
  - START: lasts exactly one cycle, then RUN with go_o=0 and timer=0.
  - RUN: timer increments each cycle.
    - done_i=1: next cycle ack[winner]=1 for one cycle, grant=0, busy=0, pointer=(winner+1) mod NREQ, state=IDLE.
    - Otherwise, cancel[winner]=1 or timer==TIMEOUT-1: next cycle state=KILL, kill_o=1, timer=0.
  - KILL: kill_o stays high for KILL_CYCLES cycles. On the cycle after the last one: kill_o=0, err[winner]=1 pulse, grant=0, busy=0, pointer advanced as above, state=IDLE.
- Latency:
  - req to go_o: 1 cycle.
  - done_i to ack: 1 cycle.
  - Job start to grant release: minimum 3 cycles.
- Back-to-back: a new arbitration cannot occur in the same cycle ack/err is driven. IDLE evaluates req in the cycle after release, so the minimum idle gap is 1 cycle.
- Simultaneous events:
  - done_i and cancel/timeout in the same RUN cycle: done wins and ack is issued, not err.
  - done_i outside RUN is ignored, including during KILL.
  - cancel on a non-granted bit is ignored.
  - Deasserting req[winner] while granted has no effect; only cancel aborts.
- Fairness: the pointer only advances past the winner. With all req high, grants rotate 0,1,..,NREQ-1,0.
- Width: timer is wide enough for TIMEOUT-1 and never wraps. It saturates conceptually because RUN always exits at TIMEOUT-1.
- Reset mid-operation: kill_o and go_o drop immediately (asynchronously), no ack/err pulse is generated, and the pointer returns to 0.
- Invariants:
  - grant is 0 or one-hot.
  - ack|err is at most one-hot and only for the bit that was granted.
  - go_o and kill_o are never high together.

Optional Feature:
- Macro JOB_ARB_STATS_EN.
- Defined: adds outputs done_cnt (16) and abort_cnt (16). done_cnt increments on each ack pulse; abort_cnt increments on each err pulse. Both saturate at 0xFFFF and reset to 0.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Single job: req=4'b0010 held; done_i pulsed 10 cycles after go_o -> go_o high 1 cycle after req, grant=0010; ack=0010 one cycle after done_i; busy=0 afterwards; pointer=2.
- Round robin: req=4'b1111 constant, each job done after 5 cycles -> grant sequence 0001,0010,0100,1000,0001, each with exactly one ack.
- Timeout: req[0] only, done_i never -> kill_o rises after TIMEOUT RUN cycles and is held KILL_CYCLES=2 cycles; then err=0001 pulse and grant=0.
- Cancel vs done: cancel[2] and done_i asserted in the same RUN cycle -> ack=0100, err=0, kill_o never high. Separately, cancel[1] while grant=0100 -> ignored.
- Reset mid-KILL: assert reset while kill_o=1 -> kill_o=0 immediately; all outputs 0; the next req[3] alone is granted 0100? no, 1000, with the pointer search starting at 0.
- Stats (JOB_ARB_STATS_EN): 3 completions and 2 timeouts -> done_cnt=3, abort_cnt=2; reset -> both 0.
